// File: rtl/ex_alu_mc_pkg.sv
// rtl/ex_alu_mc_pkg.sv - shared op codes, widths and state encoding for the EX-stage ALU
package ex_alu_mc_pkg;

    localparam int XLEN    = 32;
    localparam int SHAMT_W = 5;

    localparam logic [2:0] ALU_AND = 3'd0;
    localparam logic [2:0] ALU_XOR = 3'd1;
    localparam logic [2:0] ALU_SLL = 3'd2;
    localparam logic [2:0] ALU_ADD = 3'd3;
    localparam logic [2:0] ALU_SUB = 3'd4;
    localparam logic [2:0] ALU_MUL = 3'd5;
    localparam logic [2:0] ALU_SRA = 3'd6;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

endpackage

// File: rtl/mul_iter_32.sv
// rtl/mul_iter_32.sv - iterative shift-add multiplier, one partial product per clock
module mul_iter_32 #(
    parameter int W = ex_alu_mc_pkg::XLEN
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] product
);

    localparam int CNT_W = $clog2(W);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(W - 1);

    logic             running;
    logic [CNT_W-1:0] cnt;
    logic [W-1:0]     acc;
    logic [W-1:0]     mcand;
    logic [W-1:0]     mplier;
    logic [W-1:0]     acc_next;

    // Only the low W bits of the product are kept, so the multiplicand may shift out freely.
    assign acc_next = mplier[0] ? acc + mcand : acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            running <= 1'b0;
            cnt     <= '0;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
        end else if (start) begin
            running <= 1'b1;
            cnt     <= '0;
            acc     <= '0;
            mcand   <= a;
            mplier  <= b;
        end else if (running) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            if (cnt == LAST) begin
                running <= 1'b0;
            end
        end
    end

    assign busy    = running;
    assign done    = running && (cnt == LAST);
    assign product = acc_next;

endmodule

// File: rtl/ex_alu_mc.sv
// rtl/ex_alu_mc.sv - execute-stage ALU: single-cycle ops plus a stalling iterative MUL
module ex_alu_mc #(
    parameter int XLEN    = ex_alu_mc_pkg::XLEN,
    parameter int SHAMT_W = ex_alu_mc_pkg::SHAMT_W
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            valid_i,
    input  logic [2:0]      ALUctl_i,
    input  logic [XLEN-1:0] data1_i,
    input  logic [XLEN-1:0] data2_i,
    output logic [XLEN-1:0] result_o,
    output logic            valid_o,
    output logic            stall_o
);

    import ex_alu_mc_pkg::*;

    state_t            state_q;
    state_t            state_d;
    logic              accept_single;
    logic              mul_start;
    logic              mul_busy;
    logic              mul_done;
    logic [XLEN-1:0]   mul_product;
    logic [XLEN-1:0]   alu_y;
    logic [SHAMT_W-1:0] shamt;

    assign shamt         = data2_i[SHAMT_W-1:0];
    assign mul_start     = (state_q == IDLE) && valid_i && (ALUctl_i == ALU_MUL);
    assign accept_single = (state_q == IDLE) && valid_i && (ALUctl_i != ALU_MUL);

    always_comb begin
        alu_y = '0;
        case (ALUctl_i)
            ALU_AND: alu_y = data1_i & data2_i;
            ALU_XOR: alu_y = data1_i ^ data2_i;
            ALU_SLL: alu_y = data1_i << shamt;
            ALU_ADD: alu_y = data1_i + data2_i;
            ALU_SUB: alu_y = data1_i - data2_i;
            ALU_SRA: alu_y = $signed(data1_i) >>> shamt;
            default: alu_y = '0;
        endcase
    end

    mul_iter_32 #(.W(XLEN)) u_mul (
        .clk     (clk_i),
        .rst     (rst_i),
        .start   (mul_start),
        .a       (data1_i),
        .b       (data2_i),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (mul_start) state_d = MUL;
            MUL:     if (mul_done)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The FSM and the engine track each other; busy gates stall so an aborted run cannot linger.
    assign stall_o = (state_q == MUL) && mul_busy;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            result_o <= '0;
            valid_o  <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            if (accept_single) begin
                result_o <= alu_y;
                valid_o  <= 1'b1;
            end else if ((state_q == MUL) && mul_done) begin
                result_o <= mul_product;
                valid_o  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ex_alu_mc.sv
// tb/tb_ex_alu_mc.sv - scoreboard bench for ex_alu_mc with directed vectors
module tb_ex_alu_mc;

    import ex_alu_mc_pkg::*;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic [2:0]  ALUctl_i;
    logic [31:0] data1_i;
    logic [31:0] data2_i;
    logic [31:0] result_o;
    logic        valid_o;
    logic        stall_o;

    ex_alu_mc dut (
        .clk_i    (clk),
        .rst_i    (rst_i),
        .valid_i  (valid_i),
        .ALUctl_i (ALUctl_i),
        .data1_i  (data1_i),
        .data2_i  (data2_i),
        .result_o (result_o),
        .valid_o  (valid_o),
        .stall_o  (stall_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] val;
        int          at;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every valid_o must match the oldest expectation in value and cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_i !== 1'b1) begin
                if (valid_o === 1'b1) begin
                    if (sb.size() == 0) begin
                        chk("spurious_valid", {31'd0, valid_o}, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        chk({e.name, "_cycle"}, 32'(cyc), 32'(e.at));
                        chk(e.name, result_o, e.val);
                    end
                end else if (sb.size() > 0 && sb[0].at <= cyc) begin
                    e = sb.pop_front();
                    chk({e.name, "_valid"}, {31'd0, valid_o}, 32'd1);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input string name, input bit push);
        valid_i  = 1'b1;
        ALUctl_i = op;
        data1_i  = a;
        data2_i  = b;
        if (push) sb.push_back('{exp, cyc + 1 + ((op == ALU_MUL) ? 32 : 0), name});
        @(posedge clk);
        #1;
        valid_i = 1'b0;
    endtask

    initial begin
        int stall_cnt;
        rst_i    = 1'b1;
        valid_i  = 1'b1;
        ALUctl_i = ALU_ADD;
        data1_i  = 32'd1;
        data2_i  = 32'd2;
        repeat (2) begin
            @(negedge clk);
            chk("reset_result", result_o, 32'd0);
            chk("reset_valid", {31'd0, valid_o}, 32'd0);
            chk("reset_stall", {31'd0, stall_o}, 32'd0);
        end
        @(posedge clk);
        #1;
        rst_i   = 1'b0;
        valid_i = 1'b0;
        idle(2);

        issue(ALU_ADD, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, "add_ovf", 1);
        issue(ALU_SUB, 32'd5, 32'd7, 32'hFFFF_FFFE, "sub_neg", 1);
        issue(ALU_XOR, 32'hF0F0_F0F0, 32'hFFFF_0000, 32'h0F0F_F0F0, "xor", 1);
        issue(ALU_SLL, 32'd1, 32'd35, 32'd8, "sll_mask", 1);
        issue(ALU_SRA, 32'h8000_0000, 32'd4, 32'hF800_0000, "sra_sign", 1);
        issue(ALU_AND, 32'hFF00_FF0F, 32'h0FF0_F0FF, 32'h0F00_F00F, "and", 1);
        idle(2);

        issue(ALU_MUL, 32'd7, 32'd6, 32'd42, "mul_7x6", 1);
        stall_cnt = 0;
        repeat (32) begin
            @(negedge clk);
            if (stall_o === 1'b1) stall_cnt++;
        end
        @(negedge clk);
        chk("mul_stall_end", {31'd0, stall_o}, 32'd0);
        chk("mul_stall_cycles", 32'(stall_cnt), 32'd32);
        @(posedge clk);
        #1;
        idle(2);

        issue(ALU_MUL, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, "mul_wrap", 1);
        idle(3);
        valid_i  = 1'b1;
        ALUctl_i = ALU_ADD;
        data1_i  = 32'h1234;
        data2_i  = 32'h5;
        idle(2);
        valid_i = 1'b0;
        data1_i = 32'hDEAD_BEEF;
        data2_i = 32'h0000_0003;
        idle(32);

        issue(ALU_MUL, 32'd100, 32'd100, 32'd0, "mul_aborted", 0);
        idle(9);
        rst_i = 1'b1;
        idle(1);
        rst_i = 1'b0;
        @(negedge clk);
        chk("abort_stall", {31'd0, stall_o}, 32'd0);
        chk("abort_valid", {31'd0, valid_o}, 32'd0);
        @(posedge clk);
        #1;
        issue(ALU_ADD, 32'd3, 32'd4, 32'd7, "add_after_abort", 1);
        idle(40);

        issue(ALU_MUL, 32'd3, 32'd3, 32'd9, "b2b_mul", 1);
        valid_i  = 1'b1;
        ALUctl_i = ALU_ADD;
        data1_i  = 32'd1;
        data2_i  = 32'd1;
        sb.push_back('{32'd2, cyc + 33, "b2b_add"});
        idle(33);
        valid_i = 1'b0;
        issue(ALU_ADD, 32'd10, 32'd20, 32'd30, "add_pre7", 1);
        issue(3'd7, 32'hAAAA_AAAA, 32'h5555_5555, 32'd0, "code7", 1);
        idle(4);

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
